// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a big-endian, byte-addressed 64-bit data memory.
// Sub-doubleword stores are performed as a read-modify-write of the enclosing doubleword.
module mem_access_ctrl #(
    parameter int MEM_SIZE    = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [63:0] ReqAddr,
    input  logic [63:0] ReqWData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [63:0] RespData,
    output logic        RespErr,
    output logic [63:0] MemAddress,
    output logic [63:0] MemWriteData,
    output logic        MemoryRead,
    output logic        MemoryWrite,
    input  logic [63:0] MemReadData
);
    localparam int            CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
    state_t r_state, w_nextState;

    logic          r_write;
    logic          r_signed;
    logic [1:0]    r_size;
    logic [2:0]    r_off;
    logic [63:0]   r_wdata;
    logic [CW-1:0] r_waitCnt;

    logic          w_accept;
    logic          w_reqErr;
    logic          w_waitDone;
    logic [2:0]    w_reqNm1;
    logic [2:0]    w_nm1;
    logic [64:0]   w_reqEnd;
    logic [5:0]    w_shift;
    logic [63:0]   w_shifted;
    logic [63:0]   w_mask;
    logic [63:0]   w_loadResult;
    logic [63:0]   w_merged;

    assign w_accept   = (r_state == IDLE) && ReqValid && ReqReady;
    assign w_reqNm1   = 3'((4'd1 << ReqSize) - 4'd1);
    assign w_reqEnd   = {1'b0, ReqAddr} + {62'd0, w_reqNm1} + 65'd1;
    assign w_reqErr   = ((ReqAddr[2:0] & w_reqNm1) != 3'd0) || (w_reqEnd > 65'(MEM_SIZE));
    assign w_waitDone = (r_waitCnt == WAIT_LAST);

    // Big-endian lane at offset off with n bytes sits 8*(8-off-n) bits above bit 0.
    assign w_nm1     = 3'((4'd1 << r_size) - 4'd1);
    assign w_shift   = {3'd7 - r_off - w_nm1, 3'b000};
    assign w_shifted = MemReadData >> w_shift;

    always_comb begin
        w_mask       = 64'hFFFF_FFFF_FFFF_FFFF;
        w_loadResult = MemReadData;
        case (r_size)
            2'd0: begin
                w_mask       = 64'h0000_0000_0000_00FF;
                w_loadResult = {{56{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            2'd1: begin
                w_mask       = 64'h0000_0000_0000_FFFF;
                w_loadResult = {{48{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            end
            2'd2: begin
                w_mask       = 64'h0000_0000_FFFF_FFFF;
                w_loadResult = {{32{r_signed & w_shifted[31]}}, w_shifted[31:0]};
            end
            default: ;
        endcase
        w_merged = (MemReadData & ~(w_mask << w_shift)) | ((r_wdata & w_mask) << w_shift);
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_reqErr)                          w_nextState = RESP;
                    else if (ReqWrite && ReqSize == 2'd3)  w_nextState = WR;
                    else                                   w_nextState = RD;
                end
            end
            RD:      w_nextState = WAIT;
            WAIT:    if (w_waitDone) w_nextState = r_write ? WR : RESP;
            WR:      w_nextState = RESP;
            RESP:    if (RespReady) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    // Strobes and handshake outputs are registered from the next state so each lines up with its state.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            ReqReady     <= 1'b0;
            RespValid    <= 1'b0;
            RespErr      <= 1'b0;
            RespData     <= '0;
            MemoryRead   <= 1'b0;
            MemoryWrite  <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            r_write      <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= '0;
            r_off        <= '0;
            r_wdata      <= '0;
            r_waitCnt    <= '0;
        end else begin
            ReqReady    <= (w_nextState == IDLE);
            MemoryRead  <= (w_nextState == RD);
            MemoryWrite <= (w_nextState == WR);
            RespValid   <= (w_nextState == RESP);

            if (r_state == RD)        r_waitCnt <= '0;
            else if (r_state == WAIT) r_waitCnt <= r_waitCnt + 1'b1;

            if (w_accept) begin
                r_write      <= ReqWrite;
                r_signed     <= ReqSigned;
                r_size       <= ReqSize;
                r_off        <= ReqAddr[2:0];
                r_wdata      <= ReqWData;
                MemAddress   <= {ReqAddr[63:3], 3'b000};
                MemWriteData <= ReqWData;
                RespData     <= '0;
                RespErr      <= w_reqErr;
            end

            if (r_state == WAIT && w_waitDone) begin
                if (r_write) MemWriteData <= w_merged;
                else         RespData     <= w_loadResult;
            end

            if (r_state == RESP && RespReady) begin
                RespData <= '0;
                RespErr  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed test-plan cases plus random traffic checked
// against a byte-array memory model; a registered dword memory sits on the bus.
module tb_mem_access_ctrl;
    localparam int MEM_SIZE    = 1024;
    localparam int WAIT_CYCLES = 1;
    localparam int PERIOD      = 50;

    logic        Clock     = 1'b0;
    logic        Reset_L   = 1'b0;
    logic        ReqValid  = 1'b0;
    logic        ReqReady;
    logic        ReqWrite  = 1'b0;
    logic [1:0]  ReqSize   = 2'd0;
    logic        ReqSigned = 1'b0;
    logic [63:0] ReqAddr   = '0;
    logic [63:0] ReqWData  = '0;
    logic        RespValid;
    logic        RespReady = 1'b0;
    logic [63:0] RespData;
    logic        RespErr;
    logic [63:0] MemAddress;
    logic [63:0] MemWriteData;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [63:0] MemReadData = '0;

    int    total = 0;
    int    bad   = 0;
    string curTxn = "reset";

    logic [63:0]  tbMem  [0:MEM_SIZE/8-1];
    byte unsigned refMem [0:MEM_SIZE-1];

    mem_access_ctrl #(.MEM_SIZE(MEM_SIZE), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .Clock        (Clock),
        .Reset_L      (Reset_L),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqWrite     (ReqWrite),
        .ReqSize      (ReqSize),
        .ReqSigned    (ReqSigned),
        .ReqAddr      (ReqAddr),
        .ReqWData     (ReqWData),
        .RespValid    (RespValid),
        .RespReady    (RespReady),
        .RespData     (RespData),
        .RespErr      (RespErr),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemoryRead   (MemoryRead),
        .MemoryWrite  (MemoryWrite),
        .MemReadData  (MemReadData)
    );

    always #(PERIOD/2) Clock = ~Clock;

    // Registered memory with a 20-unit output delay.
    always @(posedge Clock) begin
        if (MemoryRead && MemAddress < 64'(MEM_SIZE))
            MemReadData <= #20 tbMem[MemAddress[9:3]];
        if (MemoryWrite && MemAddress < 64'(MEM_SIZE))
            tbMem[MemAddress[9:3]] <= MemWriteData;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s (%s): observed=0x%016h expected=0x%016h", tag, curTxn, observed, expected);
        end
    endtask

    task automatic presetDword(input int idx, input logic [63:0] v);
        tbMem[idx] = v;
        for (int k = 0; k < 8; k++) refMem[idx*8 + k] = v[63-8*k -: 8];
    endtask

    function automatic bit refErr(input logic [63:0] addr, input int nbytes);
        return ((addr % 64'(nbytes)) != 64'd0) || ((addr + 64'(nbytes)) > 64'(MEM_SIZE));
    endfunction

    function automatic logic [63:0] refLoad(input logic [63:0] addr, input int nbytes, input bit sgn);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nbytes; i++) v = (v << 8) | 64'(refMem[int'(addr) + i]);
        if (sgn && nbytes < 8 && v[8*nbytes-1]) v = v | (~64'd0 << (8*nbytes));
        return v;
    endfunction

    task automatic refStore(input logic [63:0] addr, input int nbytes, input logic [63:0] wdata);
        for (int i = 0; i < nbytes; i++) refMem[int'(addr) + i] = wdata[8*(nbytes-1-i) +: 8];
    endtask

    // One full request/response transaction; starts and ends on a falling edge.
    task automatic applyStimulus(input bit wr, input logic [1:0] size, input bit sgn,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input int hold, output logic [63:0] got);
        int          nbytes;
        bit          err;
        logic [63:0] base, expData, expWData;
        int          expLat, expRd, expWr;
        int          rdCnt, wrCnt, both, lat, guard, busyReady;
        logic [63:0] seenRAddr, seenWAddr, seenWData;
        nbytes = 1 << size;
        err    = refErr(addr, nbytes);
        base   = {addr[63:3], 3'b000};
        curTxn = $sformatf("%s size=%0d sgn=%0d addr=0x%0h", wr ? "store" : "load", size, sgn, addr);
        expData = (err || wr) ? 64'd0 : refLoad(addr, nbytes, sgn);
        expWData = '0;
        if (err)                   begin expLat = 1; expRd = 0; expWr = 0; end
        else if (wr && size == 3)  begin expLat = 2; expRd = 0; expWr = 1; end
        else if (wr)               begin expLat = 4; expRd = 1; expWr = 1; end
        else                       begin expLat = 3; expRd = 1; expWr = 0; end
        if (wr && !err) begin
            refStore(addr, nbytes, wdata);
            expWData = refLoad(base, 8, 1'b0);
        end

        guard = 0;
        while (ReqReady !== 1'b1 && guard < 20) begin
            @(negedge Clock);
            guard++;
        end
        checkOutput("ready_idle", 64'(ReqReady), 64'd1);
        ReqValid = 1'b1; ReqWrite = wr; ReqSize = size; ReqSigned = sgn; ReqAddr = addr; ReqWData = wdata;
        @(posedge Clock);
        #1 ReqValid = 1'b0;

        rdCnt = 0; wrCnt = 0; both = 0; lat = 0; busyReady = 0;
        seenRAddr = '0; seenWAddr = '0; seenWData = '0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge Clock);
            if (MemoryRead === 1'b1)  begin rdCnt++; seenRAddr = MemAddress; end
            if (MemoryWrite === 1'b1) begin wrCnt++; seenWAddr = MemAddress; seenWData = MemWriteData; end
            if (MemoryRead === 1'b1 && MemoryWrite === 1'b1) both++;
            if (ReqReady !== 1'b0) busyReady++;
            if (RespValid === 1'b1) lat = c;
        end
        got = RespData;
        checkOutput("latency", 64'(lat), 64'(expLat));
        checkOutput("resp_err", 64'(RespErr), 64'(err));
        checkOutput("resp_data", RespData, expData);
        checkOutput("read_pulses", 64'(rdCnt), 64'(expRd));
        checkOutput("write_pulses", 64'(wrCnt), 64'(expWr));
        checkOutput("strobe_overlap", 64'(both), 64'd0);
        checkOutput("ready_busy", 64'(busyReady), 64'd0);
        if (expRd == 1) checkOutput("read_addr", seenRAddr, base);
        if (expWr == 1) begin
            checkOutput("write_addr", seenWAddr, base);
            checkOutput("write_data", seenWData, expWData);
        end

        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'd3; ReqSigned = 1'b0;
                ReqAddr = 64'h18; ReqWData = '0;
            end
            @(negedge Clock);
            checkOutput("hold_valid", 64'(RespValid), 64'd1);
            checkOutput("hold_data", RespData, expData);
            checkOutput("hold_err", 64'(RespErr), 64'(err));
            checkOutput("hold_ready", 64'(ReqReady), 64'd0);
        end

        RespReady = 1'b1;
        @(posedge Clock);
        #1 RespReady = 1'b0;
        @(negedge Clock);
        checkOutput("resp_dropped", 64'(RespValid), 64'd0);
        checkOutput("ready_after", 64'(ReqReady), 64'd1);
    endtask

    initial begin
        logic [63:0] got;
        bit          wr, sgn;
        logic [1:0]  size;
        logic [63:0] addr;

        for (int i = 0; i < MEM_SIZE/8; i++) presetDword(i, {$urandom, $urandom});
        presetDword(3, 64'h0ffbea7deadbeeff);
        presetDword(4, 64'h0);

        repeat (3) @(negedge Clock);
        checkOutput("rst_req_ready", 64'(ReqReady), 64'd0);
        checkOutput("rst_resp_valid", 64'(RespValid), 64'd0);
        checkOutput("rst_resp_err", 64'(RespErr), 64'd0);
        checkOutput("rst_mem_read", 64'(MemoryRead), 64'd0);
        checkOutput("rst_mem_write", 64'(MemoryWrite), 64'd0);
        checkOutput("rst_resp_data", RespData, 64'd0);
        checkOutput("rst_mem_addr", MemAddress, 64'd0);
        checkOutput("rst_mem_wdata", MemWriteData, 64'd0);
        Reset_L = 1'b1;
        @(negedge Clock);

        applyStimulus(1'b0, 2'd3, 1'b0, 64'h18, '0, 0, got);
        checkOutput("tp_dword_18", got, 64'h0ffbea7deadbeeff);
        applyStimulus(1'b0, 2'd0, 1'b1, 64'h1D, '0, 0, got);
        checkOutput("tp_byte_1d_s", got, 64'hFFFFFFFFFFFFFFDB);
        applyStimulus(1'b0, 2'd1, 1'b0, 64'h18, '0, 0, got);
        checkOutput("tp_half_18_u", got, 64'h0000000000000FFB);
        applyStimulus(1'b0, 2'd2, 1'b1, 64'h1C, '0, 0, got);
        checkOutput("tp_word_1c_s", got, 64'hFFFFFFFFEADBEEFF);

        applyStimulus(1'b1, 2'd0, 1'b0, 64'h21, 64'hAB, 0, got);
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h20, '0, 0, got);
        checkOutput("tp_after_store", got, 64'h00AB000000000000);
        applyStimulus(1'b1, 2'd3, 1'b0, 64'h28, 64'h1122334455667788, 0, got);
        applyStimulus(1'b0, 2'd1, 1'b1, 64'h2E, '0, 0, got);

        applyStimulus(1'b0, 2'd1, 1'b0, 64'h19, '0, 0, got);
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h3FC, '0, 0, got);
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h3F8, '0, 0, got);
        applyStimulus(1'b0, 2'd0, 1'b1, 64'h3FF, '0, 0, got);
        applyStimulus(1'b1, 2'd2, 1'b0, 64'h400, 64'hDEAD, 0, got);

        applyStimulus(1'b0, 2'd2, 1'b0, 64'h1C, '0, 5, got);
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h18, '0, 0, got);

        curTxn = "reset during WAIT of half store";
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd1; ReqSigned = 1'b0;
        ReqAddr = 64'h40; ReqWData = 64'h1234;
        @(posedge Clock);
        #1 ReqValid = 1'b0;
        @(negedge Clock);
        checkOutput("rstmid_rd", 64'(MemoryRead), 64'd1);
        @(negedge Clock);
        #5 Reset_L = 1'b0;
        #1;
        checkOutput("rstmid_read_low", 64'(MemoryRead), 64'd0);
        checkOutput("rstmid_write_low", 64'(MemoryWrite), 64'd0);
        checkOutput("rstmid_resp_low", 64'(RespValid), 64'd0);
        checkOutput("rstmid_ready_low", 64'(ReqReady), 64'd0);
        repeat (3) begin
            @(negedge Clock);
            checkOutput("rstmid_no_write", 64'(MemoryWrite), 64'd0);
        end
        Reset_L = 1'b1;
        @(negedge Clock);
        checkOutput("rstmid_ready_back", 64'(ReqReady), 64'd1);
        checkOutput("rstmid_no_resp", 64'(RespValid), 64'd0);
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h40, '0, 0, got);

        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = 64'($urandom_range(0, MEM_SIZE + 15));
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'((1 << size) - 1);
            applyStimulus(wr, size, sgn, addr, {$urandom, $urandom}, (n % 10 == 3) ? 2 : 0, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the big-endian, byte-addressed 64-bit data memory.
- Accepts one load/store request at a time from the datapath over a valid/ready handshake, then drives the memory's Address/WriteData/MemoryRead/MemoryWrite strobes.
- For loads: captures the registered read doubleword, then extracts and sign/zero-extends the requested lane.
- For sub-doubleword stores: performs read-modify-write. Returns a response with valid/ready.

Parameters:
- MEM_SIZE, 1024, memory size in bytes; accesses with addr+nbytes > MEM_SIZE are errors.
- WAIT_CYCLES, 1, cycles held in WAIT after the read strobe before capturing MemReadData (≥1).

Ports:
- Clock  in  1  system clock; period must exceed the memory's 20-unit output delay.
- Reset_L  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller can accept a request.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqSize  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- ReqSigned  in  1  sign-extend load result (ignored for dword and stores).
- ReqAddr  in  64  byte address.
- ReqWData  in  64  store data, right-justified.
- RespValid  out  1  response present.
- RespReady  in  1  consumer accepts response.
- RespData  out  64  load result; 0 for stores and errors.
- RespErr  out  1  misaligned or out-of-range access.
- MemAddress  out  64  doubleword-aligned address to memory.
- MemWriteData  out  64  write data to memory.
- MemoryRead  out  1  read strobe.
- MemoryWrite  out  1  write strobe.
- MemReadData  in  64  memory read data (registered in the memory).

Behaviour:
- Reset (async, Reset_L=0):
  - State = IDLE.
  - ReqReady, RespValid, RespErr, MemoryRead, MemoryWrite = 0.
  - RespData, MemAddress, MemWriteData = 0.
  - All outputs are registered.
- ReqReady=1 only in IDLE and not in reset. Acceptance occurs on a rising edge with ReqValid & ReqReady; all request fields are latched at that edge.
- Derived values:
  - off = addr[2:0]; base = {addr[63:3],3'b000}; nbytes = 1<<ReqSize.
  - Error if (addr mod nbytes) != 0, or addr+nbytes > MEM_SIZE.
- Lane mapping (big-endian): byte at offset k is bits [63-8k -: 8] of the doubleword at base. A lane of n bytes at off occupies bits [63-8·off -: 8n].
- States: IDLE, RD, WAIT, WR, RESP.
  - IDLE -> RESP: error (no memory strobes ever asserted).
  - IDLE -> WR: dword store.
  - IDLE -> RD: load or sub-dword store.
  - RD: MemoryRead=1 and MemAddress=base for exactly one cycle. -> WAIT.
  - WAIT: MemoryRead=0; counts WAIT_CYCLES. On the final WAIT edge, MemReadData is captured.
    - Load: extracted result loaded into RespData, -> RESP.
    - Sub-dword store: merged doubleword (captured data with the target lane replaced by ReqWData's low 8n bits) loaded into MemWriteData, -> WR.
  - WR: MemoryWrite=1, MemAddress=base for exactly one cycle. Dword store uses MemWriteData=ReqWData. -> RESP.
  - RESP: RespValid=1, held with RespData and RespErr stable until RespReady=1. Handshake edge -> IDLE, and RespValid drops.
- Load extract:
  - Result = lane zero-extended, or sign-extended from the lane MSB when ReqSigned=1.
  - Dword loads pass through unchanged.
- Latency from accept edge to RespValid high (WAIT_CYCLES=1): error +1, dword store +2, load +3, sub-dword store +4.
- Back-to-back: a new request can be accepted no earlier than the edge after the response handshake; ReqReady=0 throughout RD..RESP.
- MemoryRead and MemoryWrite are never high in the same cycle; each pulses once per access.
- Reset mid-operation:
  - Returns to IDLE immediately and drops strobes asynchronously; the in-flight request is discarded with no response.
  - A write already sampled by memory may complete; this is permitted.
- ReqValid deasserting without acceptance has no effect.

Test Plan:
- Memory preloaded with 0x0ffbea7deadbeeff at 0x18. Load dword 0x18 -> RespData=0x0ffbea7deadbeeff, RespErr=0, MemoryRead one pulse, RespValid at accept+3.
- Load byte 0x1D signed -> 0xFFFFFFFFFFFFFFDB. Load half 0x18 unsigned -> 0x0000000000000FFB. Load word 0x1C signed -> 0xFFFFFFFFEADBEEFF.
- With 0x20 cleared:
  - Store byte 0xAB at 0x21 -> read, then single MemoryWrite with MemWriteData=0x00AB000000000000 at 0x20; RespValid at accept+4.
  - Subsequent dword load at 0x20 returns 0x00AB000000000000.
- Misaligned half load at 0x19 -> RespErr=1 and RespData=0 at accept+1. Dword at 0x3FC (out of range) -> RespErr=1. No strobes in either case.
- RespReady held low 5 cycles after a load -> RespValid and RespData stable, ReqReady=0, new ReqValid ignored; accepted the edge after the handshake.
- Reset_L pulsed low during WAIT of a half store -> strobes and RespValid drop immediately, no MemoryWrite issued, ReqReady=1 after release.
